memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
//  Memory stage of the single-cycle (SEQ) Y86-64 processor. Holds the data
//  memory and performs the stage's one read or one write per instruction.
//  Sits between execute (supplies valE) and write-back/PC-update (consume valM).
//  Reports out-of-range accesses on dmem_error for the status logic.
// PARAMETERS
//  MEM_BYTES  8192  data memory size in bytes, byte-addressed, addresses 0..MEM_BYTES-1
// PORTS
//  clk         in   1   clock, all writes on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  icode       in   4   instruction code of current instruction
//  valA        in   64  register value A (store data / stack pointer for pop/ret)
//  valP        in   64  incremented PC (return address stored by call)
//  valE        in   64  ALU result (effective address / new stack pointer)
//  valM        out  64  data read from memory
//  dmem_error  out  1   access address out of range
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - icode decode (Y86-64): 4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq.
//  - Address and data select:
//      read : mrmovq addr=valE; ret, popq addr=valA
//      write: rmmovq, pushq addr=valE data=valA; call addr=valE data=valP
//      all other icodes: no access, addr don't-care, dmem_error=0, valM=0.
//  - Quadwords are 8 bytes, little-endian: byte addr holds data[7:0],
//    addr+7 holds data[63:56]. No alignment requirement.
//  - Range check (unsigned, full 64-bit addr): error iff access active and
//    addr > MEM_BYTES-8. dmem_error is combinational, same cycle as inputs.
//  - Read: combinational; valM follows icode/valA/valE with no clock latency.
//    Errored read drives valM=0.
//  - Write: committed on rising clk edge when write icode, no error, rst_n=1.
//    Errored write is dropped; memory unchanged.
//  - Read-after-write: a read in the cycle after a write to the same bytes
//    returns the new data; within the write cycle valM shows pre-edge contents.
//  - Reset (rst_n=0): valM=0, dmem_error=0 immediately, writes suppressed.
//    Memory contents are NOT cleared by reset; simulation initial content is
//    all zero. Reset deassertion mid-instruction: outputs resume from current
//    inputs in the same cycle; first write occurs at next rising edge.
//  - Inputs may change at any time between edges; only values at the rising
//    edge determine writes.
// STRUCTURE
//  - Shared package: icode constants (IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9,
//    IPUSHQ=A, IPOPQ=B), shared with decode/execute/PC stages.
//  - Natural sub-module: dmem_bytes (byte array, 8-byte LE read port,
//    8-byte LE write port with enable, MEM_BYTES parameter). Top level holds
//    icode decode, address/data mux, range check, reset gating.
// TESTING
//  - icode=0 (halt), valA=valP=valE=FF -> valM=0, dmem_error=0, no write.
//  - rmmovq valE=FF valA=1234567890ABCDEF, clock; then mrmovq valE=FF ->
//    valM=1234567890ABCDEF; byte FF reads EF, byte 106 reads 12.
//  - call valE=100 valP=ABCDEF0123456789, clock; then ret valA=100 ->
//    valM=ABCDEF0123456789; popq valA=100 returns the same.
//  - pushq valE=1FF8 valA=55 -> dmem_error=0, stored; mrmovq valE=1FF9 ->
//    dmem_error=1, valM=0; rmmovq valE=FFFFFFFFFFFFFFF8 -> error, no write.
//  - rst_n=0 during rmmovq to FF across an edge -> no write, outputs 0;
//    contents written before reset still readable after rst_n=1.
//  - mrmovq valE=8 after rmmovq valE=4 (overlap) -> correct merged LE bytes.

Source files
------------

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_pkg
//  Description : Y86-64 instruction codes and memory-access classification
//                shared by the decode, execute, memory and PC-update stages.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_pkg;

    // Y86-64 instruction codes that involve the data memory
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Kind of data-memory access an instruction performs
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } mem_access_e;

    // Classify an icode by the memory access it needs
    function automatic mem_access_e decode_access(input logic [3:0] icode);
        mem_access_e acc;
        acc = ACC_NONE;
        case (icode)
            IMRMOVQ, IRET, IPOPQ:   acc = ACC_READ;
            IRMMOVQ, ICALL, IPUSHQ: acc = ACC_WRITE;
            default:                acc = ACC_NONE;
        endcase
        return acc;
    endfunction

endpackage : memory_pkg
`default_nettype wire

// File: rtl/dmem_bytes.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bytes
//  Description : Byte-addressed data memory with one combinational 8-byte
//                little-endian read port and one clocked 8-byte little-endian
//                write port sharing a single address. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_bytes #(
    parameter int MEM_BYTES = 8192,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [63:0]   wr_data,
    output logic [63:0]   rd_data
);

    // The caller only enables accesses with addr <= MEM_BYTES-8, so
    // addr+7 never leaves the array for any access that matters.
    logic [7:0] r_mem [MEM_BYTES];

    // Read port: byte addr+k lands in rd_data[8k+7:8k]
    for (genvar k = 0; k < 8; k++) begin : g_rd_byte
        logic [AW-1:0] w_idx;
        assign w_idx = addr + AW'(k);
        assign rd_data[8*k +: 8] = r_mem[w_idx];
    end

    // Write port: commit all eight bytes on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[addr + AW'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

endmodule : dmem_bytes
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module      : memory
//  Description : Memory stage of the SEQ Y86-64 processor. Decodes icode into
//                a read or write, selects address/data, range-checks the
//                access, gates everything with reset and drives valM and
//                dmem_error combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
module memory
    import memory_pkg::*;
#(
    parameter int MEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic [63:0] valE,
    output logic [63:0] valM,
    output logic        dmem_error
);

    localparam int          c_AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] c_MAX_ADDR = 64'(MEM_BYTES - 8);

    mem_access_e  w_acc;
    logic [63:0]  w_addr;
    logic [63:0]  w_wdata;
    logic         w_in_range;
    logic         w_active;
    logic         w_wr_en;
    logic [63:0]  w_rd_data;

    // Address and write-data selection per instruction
    always_comb begin
        w_acc   = decode_access(icode);
        w_addr  = valE;
        w_wdata = valA;
        case (icode)
            IRET, IPOPQ: w_addr  = valA;
            ICALL:       w_wdata = valP;
            default:     ;
        endcase
    end

    // Full 64-bit unsigned check so huge addresses never alias into the array
    assign w_in_range = (w_addr <= c_MAX_ADDR);
    assign w_active   = rst_n && (w_acc != ACC_NONE);
    assign dmem_error = w_active && !w_in_range;

    // Reset and out-of-range both suppress the store
    assign w_wr_en = rst_n && (w_acc == ACC_WRITE) && w_in_range;

    // Read data is visible only for an in-range read outside reset
    always_comb begin
        valM = '0;
        if (rst_n && (w_acc == ACC_READ) && w_in_range) begin
            valM = w_rd_data;
        end
    end

    dmem_bytes #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (c_AW)
    ) u_dmem (
        .clk     (clk),
        .addr    (w_addr[c_AW-1:0]),
        .wr_en   (w_wr_en),
        .wr_data (w_wdata),
        .rd_data (w_rd_data)
    );

endmodule : memory
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory
//  Description : Directed self-checking bench for the Y86-64 memory stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dmem_error;

    int n_checks = 0;
    int n_errors = 0;

    memory #(.MEM_BYTES(8192)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icode      (icode),
        .valA       (valA),
        .valP       (valP),
        .valE       (valE),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an instruction and let combinational outputs settle
    task automatic drive(input logic [3:0] ic, input logic [63:0] a,
                         input logic [63:0] p, input logic [63:0] e);
        icode = ic;
        valA  = a;
        valP  = p;
        valE  = e;
        #1;
    endtask

    // Cross one rising edge, return 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("reset_valM", valM, 64'h0);
        check("reset_err", {63'h0, dmem_error}, 64'h0);
        tick();
        rst_n = 1'b1;
        #1;

        // Halt: no access
        drive(4'h0, 64'hFF, 64'hFF, 64'hFF);
        check("halt_valM", valM, 64'h0);
        check("halt_err", {63'h0, dmem_error}, 64'h0);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("halt_nowrite", valM, 64'h0);

        // Non-memory icode with a wild address never errors
        drive(4'h6, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("opq_err", {63'h0, dmem_error}, 64'h0);

        // rmmovq then mrmovq
        drive(4'h4, 64'h1234_5678_90AB_CDEF, 64'h0, 64'hFF);
        check("rmmov_err", {63'h0, dmem_error}, 64'h0);
        check("rmmov_valM", valM, 64'h0);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("mrmov_ff", valM, 64'h1234_5678_90AB_CDEF);
        drive(4'h5, 64'h0, 64'h0, 64'h106);
        check("byte_106", valM, 64'h12);
        drive(4'h5, 64'h0, 64'h0, 64'hF8);
        check("byte_ff", valM, 64'hEF00_0000_0000_0000);

        // call / ret / popq
        drive(4'h8, 64'h0, 64'hABCD_EF01_2345_6789, 64'h100);
        check("call_err", {63'h0, dmem_error}, 64'h0);
        tick();
        drive(4'h9, 64'h100, 64'h0, 64'h0);
        check("ret_valM", valM, 64'hABCD_EF01_2345_6789);
        drive(4'hB, 64'h100, 64'h0, 64'h0);
        check("popq_valM", valM, 64'hABCD_EF01_2345_6789);
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("merged_ff", valM, 64'hCDEF_0123_4567_89EF);

        // Upper boundary
        drive(4'hA, 64'h55, 64'h0, 64'h1FF8);
        check("push_edge_err", {63'h0, dmem_error}, 64'h0);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'h1FF8);
        check("read_edge", valM, 64'h55);
        drive(4'h5, 64'h0, 64'h0, 64'h1FF9);
        check("read_oob_err", {63'h0, dmem_error}, 64'h1);
        check("read_oob_valM", valM, 64'h0);
        drive(4'h9, 64'h2000, 64'h0, 64'h0);
        check("ret_oob_err", {63'h0, dmem_error}, 64'h1);
        drive(4'h4, 64'hDEAD, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8);
        check("write_huge_err", {63'h0, dmem_error}, 64'h1);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'h1FF8);
        check("write_huge_drop", valM, 64'h55);

        // Reset during a store
        rst_n = 1'b0;
        drive(4'h4, 64'h1111, 64'h0, 64'hFF);
        check("rst_wr_valM", valM, 64'h0);
        check("rst_wr_err", {63'h0, dmem_error}, 64'h0);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("rst_rd_valM", valM, 64'h0);
        drive(4'h5, 64'h0, 64'h0, 64'h1FF9);
        check("rst_oob_err", {63'h0, dmem_error}, 64'h0);
        rst_n = 1'b1;
        drive(4'h5, 64'h0, 64'h0, 64'hFF);
        check("post_rst_keep", valM, 64'hCDEF_0123_4567_89EF);

        // Overlapping unaligned accesses
        drive(4'h4, 64'h8877_6655_4433_2211, 64'h0, 64'h4);
        tick();
        drive(4'h5, 64'h0, 64'h0, 64'h8);
        check("overlap_8", valM, 64'h0000_0000_8877_6655);
        drive(4'h5, 64'h0, 64'h0, 64'h0);
        check("overlap_0", valM, 64'h4433_2211_0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_memory
`default_nettype wire
